cpu7_ifu_fcl: RTL

//  Fetch control logic for the IFU front end. Sequences the instruction-cache request handshake and

---
 rtl/cpu7_ifu_fcl.sv | 116 +++++++++++
 1 files changed

// File: rtl/cpu7_ifu_fcl.sv
// IFU fetch control: cache request handshake, outstanding tracking, pc_bf select and decode-valid qualification.
// Optional perf counters are enabled with `define CPU7_IFU_FCL_PERF_EN.
module cpu7_ifu_fcl #(
  parameter int MAX_OUT = 1,
  parameter int CNT_W   = 2
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             inst_addr_ok,
  input  logic             inst_valid,
  input  logic             br_cancel,
  input  logic             dec_stall,
  output logic             inst_req,
  output logic             inst_cancel,
  output logic             fcl_fdp_pcbf_sel_init_l,
  output logic             fcl_fdp_pcbf_sel_old_l,
  output logic             fcl_fdp_pcbf_sel_pcinc_l,
  output logic             fcl_fdp_pcbf_sel_brpc_l,
  output logic             fcl_dec_valid,
  output logic [CNT_W-1:0] fcl_outstanding
`ifdef CPU7_IFU_FCL_PERF_EN
  ,
  output logic [31:0]      fcl_perf_fetch_cnt,
  output logic [31:0]      fcl_perf_cancel_cnt
`endif
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  state_t           state;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] drain_cnt;
  logic [CNT_W-1:0] out_cnt_next;
  logic             in_run;
  logic             cancel_ok;
  logic             accept;
  logic             retire;

  always_comb begin
    in_run        = (state == ST_RUN);
    cancel_ok     = br_cancel && (state != ST_INIT);
    inst_req      = in_run && (out_cnt < MAX_CNT) && !dec_stall && !br_cancel;
    inst_cancel   = cancel_ok;
    accept        = inst_req && inst_addr_ok;
    // A response with nothing outstanding is a protocol error and is ignored.
    retire        = inst_valid && (out_cnt != '0);
    fcl_dec_valid = retire && in_run && !br_cancel && !dec_stall;

    out_cnt_next = out_cnt;
    if (accept && !retire)
      out_cnt_next = out_cnt + CNT_W'(1);
    else if (!accept && retire)
      out_cnt_next = out_cnt - CNT_W'(1);

    fcl_fdp_pcbf_sel_init_l  = 1'b1;
    fcl_fdp_pcbf_sel_old_l   = 1'b1;
    fcl_fdp_pcbf_sel_pcinc_l = 1'b1;
    fcl_fdp_pcbf_sel_brpc_l  = 1'b1;
    if (state == ST_INIT)
      fcl_fdp_pcbf_sel_init_l = 1'b0;
    else if (cancel_ok)
      fcl_fdp_pcbf_sel_brpc_l = 1'b0;
    else if (fcl_dec_valid)
      fcl_fdp_pcbf_sel_pcinc_l = 1'b0;
    else
      fcl_fdp_pcbf_sel_old_l = 1'b0;

    fcl_outstanding = out_cnt;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_INIT;
      out_cnt   <= '0;
      drain_cnt <= '0;
    end else begin
      out_cnt <= out_cnt_next;
      case (state)
        ST_INIT: state <= ST_RUN;
        ST_RUN, ST_DRAIN: begin
          // A redirect (re)starts the drain with whatever is still in flight after this cycle.
          if (br_cancel) begin
            if (out_cnt_next != '0) begin
              drain_cnt <= out_cnt_next;
              state     <= ST_DRAIN;
            end else begin
              state <= ST_RUN;
            end
          end else if ((state == ST_DRAIN) && retire) begin
            drain_cnt <= drain_cnt - CNT_W'(1);
            if (drain_cnt == CNT_W'(1))
              state <= ST_RUN;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef CPU7_IFU_FCL_PERF_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fcl_perf_fetch_cnt  <= '0;
      fcl_perf_cancel_cnt <= '0;
    end else begin
      if (fcl_dec_valid)
        fcl_perf_fetch_cnt <= fcl_perf_fetch_cnt + 32'd1;
      if (cancel_ok)
        fcl_perf_cancel_cnt <= fcl_perf_cancel_cnt + 32'd1;
    end
  end
`endif

endmodule
